// File: rtl/uk101_pkg.sv
// Shared constants and types for the UK101 text-file loader path.
package uk101_pkg;

  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] TXT_IOCTL_INDEX = 8'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } feeder_state_e;

  // A gap of zero cycles would underflow the counter load, so it is raised to one.
  function automatic int gap_floor(input int gap);
    return (gap < 1) ? 1 : gap;
  endfunction

endpackage

// File: rtl/uk101_byte_fifo.sv
// Synchronous byte FIFO feeding the ACIA text path; flush overrides push and pop.
module uk101_byte_fifo
  import uk101_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uk101_ioctl_txt_feeder.sv
// Buffers an ASCII file from the HPS ioctl download and paces it into the UK101 ACIA receiver.
module uk101_ioctl_txt_feeder
  import uk101_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 48000,
  parameter int LINE_GAP   = 960000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_index,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       overflow
);

  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int CHAR_EFF = gap_floor(CHAR_GAP);
  localparam int LINE_EFF = gap_floor(LINE_GAP);
  localparam int GAP_MAX  = (CHAR_EFF > LINE_EFF) ? CHAR_EFF : LINE_EFF;
  localparam int GAP_W    = ($clog2(GAP_MAX) < 1) ? 1 : $clog2(GAP_MAX);

  localparam logic [GAP_W-1:0] CHAR_LOAD  = GAP_W'(CHAR_EFF - 1);
  localparam logic [GAP_W-1:0] LINE_LOAD  = GAP_W'(LINE_EFF - 1);
  localparam logic [CW-1:0]    WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

  feeder_state_e    state_q, state_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             overflow_q, overflow_d;
  logic             wait_q, wait_d;
  logic             dl_q, en_q;

  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  logic accept, push, pop, dl_rise, en_fall, flush;

  assign accept  = ioctl_download & ioctl_wr & enable & (ioctl_index == TXT_IOCTL_INDEX);
  assign push    = accept & (ioctl_dout != ASCII_LF);
  assign dl_rise = ioctl_download & ~dl_q & enable;
  assign en_fall = en_q & ~enable;
  assign flush   = dl_rise | en_fall;
  assign pop     = (state_q == IDLE) & ~fifo_empty & ~flush;

  uk101_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (ioctl_dout),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    gap_cnt_d  = gap_cnt_q;
    if (flush) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            rx_data_d  = fifo_dout;
            rx_valid_d = 1'b1;
            state_d    = PRESENT;
          end
        end
        PRESENT: begin
          if (rx_ack) begin
            rx_valid_d = 1'b0;
            gap_cnt_d  = (rx_data_q == ASCII_CR) ? LINE_LOAD : CHAR_LOAD;
            state_d    = GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_d = IDLE;
          else                 gap_cnt_d = gap_cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO drops the byte even if a pop frees a slot in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (dl_rise)                overflow_d = 1'b0;
    else if (push && fifo_full) overflow_d = 1'b1;
  end

  assign wait_d = (fifo_count >= WAIT_LEVEL);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      gap_cnt_q  <= '0;
      overflow_q <= 1'b0;
      wait_q     <= 1'b0;
      dl_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      gap_cnt_q  <= gap_cnt_d;
      overflow_q <= overflow_d;
      wait_q     <= wait_d;
      dl_q       <= ioctl_download;
      en_q       <= enable;
    end
  end

  assign ioctl_wait = wait_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overflow   = overflow_q;
  assign busy       = ioctl_download | ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_uk101_ioctl_txt_feeder.sv
// Scenario bench for the ioctl text feeder: expected characters and timings come from a queue model.
module tb_uk101_ioctl_txt_feeder;

  localparam int DEPTH   = 16;
  localparam int CGAP    = 20;
  localparam int LGAP    = 60;
  localparam int ACK_DLY = 3;

  logic       clk = 1'b0;
  logic       rst, enable, ioctl_download, ioctl_wr, rx_ack;
  logic [7:0] ioctl_index, ioctl_dout, rx_data;
  logic       ioctl_wait, rx_valid, busy, overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit ack_en       = 1'b0;

  logic [7:0] got_q[$];
  int         rise_q[$];
  int         ack_q[$];

  uk101_ioctl_txt_feeder #(
    .FIFO_DEPTH (DEPTH),
    .CHAR_GAP   (CGAP),
    .LINE_GAP   (LGAP)
  ) dut (
    .clk_sys        (clk),
    .reset          (rst),
    .enable         (enable),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ack         (rx_ack),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ACIA stand-in: records each presentation and acks it ACK_DLY cycles after it appears.
  initial begin : acker
    int age;
    age    = 0;
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      rx_ack = 1'b0;
      if (rx_valid === 1'b1) begin
        if (age == 0) rise_q.push_back(cyc);
        if (ack_en && age >= ACK_DLY) begin
          rx_ack = 1'b1;
          got_q.push_back(rx_data);
          ack_q.push_back(cyc);
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  function automatic int gap_for(input logic [7:0] b);
    return (b == 8'h0D) ? LGAP : CGAP;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    rise_q.delete();
    ack_q.delete();
  endtask

  task automatic start_download();
    @(negedge clk);
    ioctl_download = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int t;
    t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    string      msg;
    logic [7:0] exp_q[$];
    int         s0, fall, n, want;
    msg = "10 PRINT 1\r\n";
    clear_mon();
    ack_en = 1'b1;
    start_download();
    s0 = -1;
    for (int i = 0; i < msg.len(); i++) begin
      strobe(msg[i]);
      if (i == 0) s0 = cyc;
      if (msg[i] != 8'h0A) exp_q.push_back(msg[i]);
    end
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    n = exp_q.size();
    wait_got(n, 4000);
    tests_run++;
    if (got_q.size() != n || rise_q.size() != n) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d chars / %0d presentations, want %0d", got_q.size(), rise_q.size(), n);
    end else begin
      tests_run++;
      if (rise_q[0] - s0 != 2) begin tests_failed++; $display("FAIL stream_latency: got %0d cycles want 2", rise_q[0] - s0); end
      for (int i = 0; i < n; i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stream_char[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < n; i++) begin
        want = gap_for(exp_q[i-1]) + 2;
        tests_run++;
        if (rise_q[i] - ack_q[i-1] != want) begin
          tests_failed++;
          $display("FAIL stream_gap[%0d]: got %0d cycles want %0d", i, rise_q[i] - ack_q[i-1], want);
        end
      end
      fall = -1;
      for (int t = 0; t < LGAP + 50; t++) begin
        if (busy === 1'b0) begin fall = cyc; break; end
        @(negedge clk);
      end
      want = ack_q[n-1] + LGAP + 1;
      tests_run++;
      if (fall != want) begin tests_failed++; $display("FAIL stream_busy_fall: got cycle %0d want %0d", fall, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data[20];
    int         idx, wr_at_wait;
    clear_mon();
    ack_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data[i] = 8'($urandom_range(0, 255));
      if (data[i] == 8'h0A) data[i] = 8'h0B;
    end
    start_download();
    idx        = 0;
    wr_at_wait = -1;
    for (int t = 0; t < 3000 && idx < 20; t++) begin
      @(negedge clk);
      if (t == 60) ack_en = 1'b1;
      if (ioctl_wait === 1'b1 && wr_at_wait < 0) wr_at_wait = idx;
      if (ioctl_wait === 1'b0) begin
        ioctl_wr   = 1'b1;
        ioctl_dout = data[idx];
        idx++;
      end else begin
        ioctl_wr = 1'b0;
      end
    end
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tests_run++;
    if (wr_at_wait != DEPTH + 1) begin tests_failed++; $display("FAIL b2b_wait_rise: wait after %0d writes want %0d", wr_at_wait, DEPTH + 1); end
    wait_got(20, 5000);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    tests_run++;
    if (got_q.size() != 20) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d chars want 20", got_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        tests_run++;
        if (got_q[i] !== data[i]) begin tests_failed++; $display("FAIL b2b_char[%0d]: got %h want %h", i, got_q[i], data[i]); end
      end
    end
    wait_idle(500);
  endtask

  task automatic test_overflow();
    logic [7:0] data[20];
    logic [7:0] exp_q[$];
    clear_mon();
    ack_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data[i] = 8'($urandom_range(0, 255));
      if (data[i] == 8'h0A) data[i] = 8'h0C;
    end
    // One byte is held in the presentation register and DEPTH more fit in the FIFO.
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(data[i]);
    start_download();
    for (int i = 0; i < 20; i++) strobe(data[i]);
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    ack_en = 1'b1;
    wait_got(exp_q.size(), 5000);
    wait_idle(2000);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d chars want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL ovf_char[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    start_download();
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear_on_start: got %b want 0", overflow); end
    ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_filter();
    clear_mon();
    ack_en      = 1'b1;
    ioctl_index = 8'd1;
    start_download();
    for (int i = 0; i < 5; i++) strobe(8'h41 + 8'(i));
    bus_idle();
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL idx1_busy_dl: got %b want 1", busy); end
    ioctl_download = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idx1_busy_end: got %b want 0", busy); end
    ioctl_index = 8'd0;
    enable      = 1'b0;
    @(negedge clk);
    start_download();
    for (int i = 0; i < 5; i++) strobe(8'h61 + 8'(i));
    bus_idle();
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL dis_busy_dl: got %b want 1", busy); end
    ioctl_download = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL dis_busy_end: got %b want 0", busy); end
    tests_run++; if (rise_q.size() != 0) begin tests_failed++; $display("FAIL filter_no_rx: got %0d presentations want 0", rise_q.size()); end
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_restart();
    int s;
    clear_mon();
    ack_en = 1'b0;
    start_download();
    strobe(8'h41);
    strobe(8'h42);
    strobe(8'h43);
    bus_idle();
    @(negedge clk);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h41) begin
      tests_failed++;
      $display("FAIL restart_present: got valid=%b data=%h want valid=1 data=41", rx_valid, rx_data);
    end
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_drop: got %b want 0", rx_valid); end
    ioctl_wr   = 1'b1;
    ioctl_dout = 8'h55;
    s          = cyc;
    @(negedge clk);
    ioctl_wr = 1'b0;
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_flushed: got valid=%b data=%h at +1", rx_valid, rx_data); end
    @(negedge clk);
    tests_run++;
    if (cyc - s != 2 || rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      tests_failed++;
      $display("FAIL restart_first_byte: got valid=%b data=%h want valid=1 data=55", rx_valid, rx_data);
    end
    ioctl_download = 1'b0;
    ack_en         = 1'b1;
    wait_got(1, 200);
    wait_idle(500);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      tests_failed++;
      $display("FAIL restart_drain: got %0d chars first=%h want 1 char 55", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    ack_en = 1'b1;
    start_download();
    strobe(8'h41);
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    wait_got(1, 200);
    repeat (5) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy: got %b want 0", busy); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL areset_rx_data: got %h want 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_rx_valid: got %b want 0", rx_valid); end
    tests_run++; if (ioctl_wait !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL areset_flags: got wait=%b ovf=%b want 0 0", ioctl_wait, overflow); end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (2 * CGAP) @(negedge clk);
    tests_run++; if (rise_q.size() != 0) begin tests_failed++; $display("FAIL areset_stale: got %0d presentations want 0", rise_q.size()); end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_dout     = 8'h00;
    test_reset();
    test_stream();
    test_back_to_back();
    test_overflow();
    test_filter();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
